// File: rtl/ariane_pkg.sv
// Shared types and constants for the evu_ctrl performance-event counter block.
package ariane_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } evu_state_e;

  // Bit order matches the EVSEL register: [5] irq_en, [4] enable, [3:0] sel.
  typedef struct packed {
    logic       irq_en;
    logic       enable;
    logic [3:0] sel;
  } evsel_t;

  localparam logic [3:0] EVU_ADDR_CTRL        = 4'd0;
  localparam logic [3:0] EVU_ADDR_WINDOW      = 4'd1;
  localparam logic [3:0] EVU_ADDR_STATUS      = 4'd2;
  localparam logic [3:0] EVU_ADDR_OVFCLR      = 4'd3;
  localparam logic [3:0] EVU_ADDR_CNT_BASE    = 4'd4;
  localparam logic [3:0] EVU_ADDR_EVSEL_BASE  = 4'd8;
  localparam logic [3:0] EVU_ADDR_SHADOW_BASE = 4'd12;

  localparam logic [3:0] EVU_SEL_CYCLES      = 4'd0;
  localparam logic [3:0] EVU_SEL_RESERVED    = 4'd1;
  localparam logic [3:0] EVU_SEL_ICACHE_MISS = 4'd2;
  localparam logic [3:0] EVU_SEL_IF_EMPTY    = 4'd15;

endpackage

// File: rtl/evu_counter.sv
// One event counter: event-select mux, wrapping increment, sticky overflow flag.
module evu_counter
  import ariane_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [15:0]      evt_i,
  input  evsel_t           evsel_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             w1c_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_evt;
  logic             w_inc;
  logic             w_wrap;

  always_comb begin
    w_evt = 1'b0;
    case (evsel_i.sel)
      EVU_SEL_CYCLES:   w_evt = 1'b1;
      EVU_SEL_RESERVED: w_evt = 1'b0;
      default:          w_evt = evt_i[evsel_i.sel];
    endcase
  end

  assign w_inc  = run_i & evsel_i.enable & w_evt;
  assign w_wrap = w_inc & (&r_cnt);

  // A software write to the counter swallows a coincident increment and its wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clr_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (we_i) begin
        r_cnt <= wdata_i;
      end else if (w_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_ovf <= (r_ovf & ~w1c_i) | (w_wrap & ~we_i);
    end
  end

  assign cnt_o = r_cnt;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/evu_ctrl.sv
// Performance-event counter controller: register port, measurement FSM, irq.
// Optional EVU_SHADOW_EN snapshots the counters into SHADOW[i] on entry to DONE.
module evu_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned NUM_EVT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_EVT-1:0]   evt_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [3:0]           cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [31:0]          cfg_rdata_o,
  output logic [4*NUM_CNT-1:0] sel_o,
  output logic                 ovf_irq_o,
  output logic                 window_done_o
);

  evu_state_e         r_state, w_state_nxt;
  logic [31:0]        r_window, r_win_cnt, w_win_cnt_nxt;
  evsel_t             r_evsel [NUM_CNT];
  logic [CNT_W-1:0]   w_cnt [NUM_CNT];
  logic [NUM_CNT-1:0] w_ovf, w_irq_src, w_cnt_we;
  logic               r_rvalid, r_irq;
  logic [31:0]        r_rdata, w_rdata;
  logic               w_wr, w_rd, w_ctrl_wr, w_start, w_stop, w_clr, w_w1c, w_run;

  assign w_wr      = cfg_req_i & cfg_we_i;
  assign w_rd      = cfg_req_i & ~cfg_we_i;
  assign w_ctrl_wr = w_wr && (cfg_addr_i == EVU_ADDR_CTRL);
  assign w_start   = w_ctrl_wr & cfg_wdata_i[0];
  assign w_stop    = w_ctrl_wr & cfg_wdata_i[1];
  assign w_clr     = w_ctrl_wr & cfg_wdata_i[2];
  assign w_w1c     = w_wr && (cfg_addr_i == EVU_ADDR_OVFCLR);
  assign w_run     = (r_state == RUN);

  // A zero window counter while in RUN means unbounded: it never decrements.
  always_comb begin
    w_state_nxt   = r_state;
    w_win_cnt_nxt = r_win_cnt;
    if (w_start) begin
      w_state_nxt   = RUN;
      w_win_cnt_nxt = r_window;
    end else if ((w_stop || w_clr) && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
    end else if (w_run && (r_win_cnt != '0)) begin
      w_win_cnt_nxt = r_win_cnt - 32'd1;
      if (r_win_cnt == 32'd1) begin
        w_state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_win_cnt <= '0;
      r_window  <= '0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        r_evsel[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_win_cnt <= w_win_cnt_nxt;
      if (w_wr && (cfg_addr_i == EVU_ADDR_WINDOW)) begin
        r_window <= cfg_wdata_i;
      end
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (w_wr && (cfg_addr_i == EVU_ADDR_EVSEL_BASE + 4'(i))) begin
          r_evsel[i] <= evsel_t'(cfg_wdata_i[5:0]);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    assign w_cnt_we[g]  = w_wr && (cfg_addr_i == EVU_ADDR_CNT_BASE + 4'(g));
    assign w_irq_src[g] = w_ovf[g] & r_evsel[g].irq_en;
    assign sel_o[4*g +: 4] = r_evsel[g].sel;

    evu_counter #(
      .CNT_W (CNT_W)
    ) u_counter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .run_i   (w_run),
      .clr_i   (w_clr),
      .evt_i   (evt_i),
      .evsel_i (r_evsel[g]),
      .we_i    (w_cnt_we[g]),
      .wdata_i (cfg_wdata_i[CNT_W-1:0]),
      .w1c_i   (w_w1c & cfg_wdata_i[g]),
      .cnt_o   (w_cnt[g]),
      .ovf_o   (w_ovf[g])
    );
  end

`ifdef EVU_SHADOW_EN
  logic [CNT_W-1:0] r_shadow [NUM_CNT];
  logic             r_snap;

  // The copy lands one cycle after DONE entry from the (then frozen) counters;
  // reads during that cycle bypass to the live counters so the timing matches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_snap <= 1'b0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_snap <= (w_state_nxt == DONE) && (r_state != DONE);
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (r_snap) begin
          r_shadow[i] <= w_cnt[i];
        end
      end
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (cfg_addr_i[3:2])
      2'b00: begin
        if (cfg_addr_i == EVU_ADDR_WINDOW) begin
          w_rdata = r_window;
        end else if (cfg_addr_i == EVU_ADDR_STATUS) begin
          w_rdata[1:0]         = r_state;
          w_rdata[8 +: NUM_CNT] = w_ovf;
        end
      end
      2'b01: begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
          if (cfg_addr_i[1:0] == 2'(i)) w_rdata = 32'(w_cnt[i]);
        end
      end
      2'b10: begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
          if (cfg_addr_i[1:0] == 2'(i)) w_rdata = 32'(r_evsel[i]);
        end
      end
`ifdef EVU_SHADOW_EN
      2'b11: begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
          if (cfg_addr_i[1:0] == 2'(i)) w_rdata = r_snap ? 32'(w_cnt[i]) : 32'(r_shadow[i]);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= cfg_req_i;
      r_rdata  <= w_rd ? w_rdata : '0;
      r_irq    <= |w_irq_src;
    end
  end

  assign cfg_gnt_o     = cfg_req_i;
  assign cfg_rvalid_o  = r_rvalid;
  assign cfg_rdata_o   = r_rdata;
  assign ovf_irq_o     = r_irq;
  assign window_done_o = (r_state == DONE);

endmodule
